// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the logic-unit arbiter.
package logic_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_NAND = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus between the requesters and the logic-unit arbiter.
interface logic_unit_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 2,
   parameter int ID_W  = 1
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*3-1:0]     req_op;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_zero;

   modport master (
      output req_valid, req_op, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req_valid, req_op, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );
endinterface

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational 8-function bitwise logic unit with zero flag.
module logic_unit
   import logic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   // Select the bitwise function; y is ignored for NOT and PASS.
   always_comb begin
      out = '0;
      unique case (op)
         OP_AND:  out = x & y;
         OP_NAND: out = ~(x & y);
         OP_OR:   out = x | y;
         OP_NOR:  out = ~(x | y);
         OP_XOR:  out = x ^ y;
         OP_XNOR: out = ~(x ^ y);
         OP_NOT:  out = ~x;
         OP_PASS: out = x;
         default: out = '0;
      endcase
   end

   assign zero = (out == '0);

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between NREQ requesters.
// One transaction at a time: IDLE (grant/capture) -> EXEC -> RESP.
module logic_unit_arbiter
   import logic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREQ  = 2,
   parameter int ID_W  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   logic_unit_arbiter_if.slave  bus,
   output logic                 busy
);

   state_t            state, state_n;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic              accept;
   logic [NREQ-1:0]   ready_n;
   int unsigned       rr_idx;

   logic [2:0]        op_q;
   logic [WIDTH-1:0]  x_q, y_q;
   logic [ID_W-1:0]   id_q;

   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [WIDTH-1:0]  rsp_data_q;
   logic              rsp_zero_q;

   logic [WIDTH-1:0]  lu_out;
   logic              lu_zero;

   // Circular search for the first pending request after the last grant.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         rr_idx = (int'(last_grant) + k) % NREQ;
         if (!grant_any && bus.req_valid[rr_idx]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(rr_idx);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next state and combinational ready; ready is held low while in reset.
   always_comb begin
      state_n = state;
      ready_n = '0;
      accept  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rst && grant_any) begin
               ready_n[grant_idx] = 1'b1;
               accept             = 1'b1;
               state_n            = S_EXEC;
            end
         end
         S_EXEC: state_n = S_RESP;
         S_RESP: begin
            if (rsp_valid_q && bus.rsp_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Operand capture on accept, result registration in EXEC, response handshake in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant  <= ID_W'(NREQ - 1);
         op_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q       <= bus.req_op[3*grant_idx +: 3];
            x_q        <= bus.req_x[WIDTH*grant_idx +: WIDTH];
            y_q        <= bus.req_y[WIDTH*grant_idx +: WIDTH];
            id_q       <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == S_EXEC) begin
            rsp_data_q  <= lu_out;
            rsp_zero_q  <= lu_zero;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
         end else if (state == S_RESP && rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   logic_unit #(.WIDTH(WIDTH)) u_lu (
      .x    (x_q),
      .y    (y_q),
      .op   (op_q),
      .out  (lu_out),
      .zero (lu_zero)
   );

   assign bus.req_ready = ready_n;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign busy          = (state != S_IDLE);

endmodule
